// File: rtl/if_id_pkg.sv
// if_id_pkg: shared definitions for the IF/ID boundary.
// Holds the MIPS fixed-format field positions, the default NOP encoding,
// the decoded field struct and a helper that splits an instruction word.
package if_id_pkg;

  localparam int unsigned OP_HI    = 31;
  localparam int unsigned OP_LO    = 26;
  localparam int unsigned RS_HI    = 25;
  localparam int unsigned RS_LO    = 21;
  localparam int unsigned RT_HI    = 20;
  localparam int unsigned RT_LO    = 16;
  localparam int unsigned RD_HI    = 15;
  localparam int unsigned RD_LO    = 11;
  localparam int unsigned SHAMT_HI = 10;
  localparam int unsigned SHAMT_LO = 6;
  localparam int unsigned FUNC_HI  = 5;
  localparam int unsigned FUNC_LO  = 0;

  // sll $0,$0,0 -- the canonical MIPS NOP
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] func;
  } instr_fields_t;

  // Split a 32-bit instruction word into its fixed fields.
  function automatic instr_fields_t decode_fields(input logic [31:0] instr);
    instr_fields_t f;
    f.op    = instr[OP_HI:OP_LO];
    f.rs    = instr[RS_HI:RS_LO];
    f.rt    = instr[RT_HI:RT_LO];
    f.rd    = instr[RD_HI:RD_LO];
    f.shamt = instr[SHAMT_HI:SHAMT_LO];
    f.func  = instr[FUNC_HI:FUNC_LO];
    return f;
  endfunction

endpackage

// File: rtl/if_id_skid_reg_sat_counter.sv
// sat_counter: W-bit up counter that increments when inc is high and
// sticks at all-ones.
// Ports: clk, rst (async, active-high), inc -> cnt (registered).
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Increment unless already saturated
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/if_id_skid_reg.sv
// if_id_skid_reg: elastic IF/ID pipeline boundary with a main entry and a
// one-beat skid entry, so in_ready comes straight from a flop.
// Ports:
//   clk, rst              clock, async active-high reset
//   in_valid/in_ready     fetch handshake (in_ready registered)
//   in_instr, in_pc       fetched beat
//   flush                 drop every held beat, load FLUSH_INSTR
//   out_valid/out_ready   decode handshake
//   out_instr, out_pc     main entry payload
//   out_pc_next           out_pc + PC_INC
//   out_op..out_func      MIPS fields of out_instr
//   stall_cnt, flush_cnt  saturating performance counters
import if_id_pkg::*;

module if_id_skid_reg #(
  parameter int unsigned    XLEN        = 32,
  parameter int unsigned    ILEN        = 32,
  parameter int unsigned    PC_INC      = 4,
  parameter logic [ILEN-1:0] FLUSH_INSTR = ILEN'(NOP_INSTR),
  parameter int unsigned    CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ILEN-1:0]  in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ILEN-1:0]  out_instr,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_pc_next,
  output logic [5:0]       out_op,
  output logic [4:0]       out_rs,
  output logic [4:0]       out_rt,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_shamt,
  output logic [5:0]       out_func,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic            main_valid_q, main_valid_d;
  logic [ILEN-1:0] main_instr_q, main_instr_d;
  logic [XLEN-1:0] main_pc_q,    main_pc_d;
  logic            skid_valid_q, skid_valid_d;
  logic [ILEN-1:0] skid_instr_q, skid_instr_d;
  logic [XLEN-1:0] skid_pc_q,    skid_pc_d;
  logic            in_ready_q,   in_ready_d;

  logic accept;
  logic drain;
  logic stall;

  assign accept = in_valid & in_ready_q;
  assign drain  = main_valid_q & out_ready;
  assign stall  = main_valid_q & ~out_ready;

  // Next-state for the main/skid entries; flush overrides everything
  always_comb begin
    main_valid_d = main_valid_q;
    main_instr_d = main_instr_q;
    main_pc_d    = main_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      main_instr_d = FLUSH_INSTR;
    end else if (drain && skid_valid_q) begin
      main_valid_d = 1'b1;
      main_instr_d = skid_instr_q;
      main_pc_d    = skid_pc_q;
      skid_valid_d = accept;
      if (accept) begin
        skid_instr_d = in_instr;
        skid_pc_d    = in_pc;
      end
    end else if (drain || !main_valid_q) begin
      // Main is free this cycle: take the accepted beat, if any
      main_valid_d = accept;
      if (accept) begin
        main_instr_d = in_instr;
        main_pc_d    = in_pc;
      end
    end else if (accept) begin
      // Main is stalled: park the new beat in skid
      skid_valid_d = 1'b1;
      skid_instr_d = in_instr;
      skid_pc_d    = in_pc;
    end

    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_instr_q <= FLUSH_INSTR;
      main_pc_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= FLUSH_INSTR;
      skid_pc_q    <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      main_valid_q <= main_valid_d;
      main_instr_q <= main_instr_d;
      main_pc_q    <= main_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      in_ready_q   <= in_ready_d;
    end
  end

  // Field decode and sequential PC, from main-entry flops only
  instr_fields_t fields;
  assign fields = decode_fields(32'(main_instr_q));

  assign in_ready    = in_ready_q;
  assign out_valid   = main_valid_q;
  assign out_instr   = main_instr_q;
  assign out_pc      = main_pc_q;
  assign out_pc_next = main_pc_q + XLEN'(PC_INC);
  assign out_op      = fields.op;
  assign out_rs      = fields.rs;
  assign out_rt      = fields.rt;
  assign out_rd      = fields.rd;
  assign out_shamt   = fields.shamt;
  assign out_func    = fields.func;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall),
    .cnt (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush),
    .cnt (flush_cnt)
  );

endmodule

// File: tb/tb_if_id_skid_reg.sv
module tb_if_id_skid_reg;

  localparam logic [31:0] ADD_INSTR = 32'h012A_4020;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_ready;

  logic        in_ready, out_valid;
  logic [31:0] out_instr, out_pc, out_pc_next;
  logic [5:0]  out_op, out_func;
  logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
  logic [15:0] stall_cnt, flush_cnt;

  logic        d2_in_ready, d2_out_valid;
  logic [31:0] d2_out_instr, d2_out_pc, d2_out_pc_next;
  logic [5:0]  d2_out_op, d2_out_func;
  logic [4:0]  d2_out_rs, d2_out_rt, d2_out_rd, d2_out_shamt;
  logic [1:0]  d2_stall_cnt, d2_flush_cnt;

  int vecs = 0;
  int errs = 0;

  // Reference model: ordered list of held beats (at most two), the payload
  // last shown on the outputs, and unbounded event counts.
  logic [63:0] mq[$];
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  int          m_stall;
  int          m_flush;

  always #5 clk = ~clk;

  if_id_skid_reg u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_pc_next(out_pc_next), .out_op(out_op),
    .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .out_shamt(out_shamt), .out_func(out_func),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  if_id_skid_reg #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d2_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(d2_out_valid), .out_ready(out_ready),
    .out_instr(d2_out_instr), .out_pc(d2_out_pc),
    .out_pc_next(d2_out_pc_next), .out_op(d2_out_op), .out_rs(d2_out_rs),
    .out_rt(d2_out_rt), .out_rd(d2_out_rd), .out_shamt(d2_out_shamt),
    .out_func(d2_out_func), .stall_cnt(d2_stall_cnt),
    .flush_cnt(d2_flush_cnt)
  );

  function automatic int sat(input int v, input int lim);
    return (v < lim) ? v : lim;
  endfunction

  function automatic logic [295:0] act_vec();
    return {in_ready, out_valid, out_instr, out_pc, out_pc_next, out_op,
            out_rs, out_rt, out_rd, out_shamt, out_func, stall_cnt, flush_cnt,
            d2_in_ready, d2_out_valid, d2_out_instr, d2_out_pc,
            d2_out_pc_next, d2_out_op, d2_out_rs, d2_out_rt, d2_out_rd,
            d2_out_shamt, d2_out_func, d2_stall_cnt, d2_flush_cnt};
  endfunction

  function automatic logic [295:0] exp_vec();
    logic [31:0]  i;
    logic [129:0] core;
    i = m_instr;
    core = {(mq.size() < 2), (mq.size() > 0), i, m_pc, m_pc + 32'd4,
            i[31:26], i[25:21], i[20:16], i[15:11], i[10:6], i[5:0]};
    return {core, 16'(sat(m_stall, 65535)), 16'(sat(m_flush, 65535)),
            core, 2'(sat(m_stall, 3)), 2'(sat(m_flush, 3))};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_instr = 32'h0;
    m_pc    = 32'h0;
    m_stall = 0;
    m_flush = 0;
  endtask

  // Apply one clock of the model using the inputs now driven, then clock.
  task automatic advance();
    bit acc, drn;
    acc = in_valid && (mq.size() < 2);
    drn = (mq.size() > 0) && out_ready;
    if ((mq.size() > 0) && !out_ready) m_stall++;
    if (flush) begin
      m_flush++;
      mq.delete();
      m_instr = 32'h0;
    end else begin
      if (drn) void'(mq.pop_front());
      if (acc) mq.push_back({in_instr, in_pc});
      if (mq.size() > 0) begin
        m_instr = mq[0][63:32];
        m_pc    = mq[0][31:0];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    flush = 1'b0; out_ready = 1'b1;
    model_reset();
    @(negedge clk);
    vecs++;
    if (act_vec() !== exp_vec()) begin
      errs++;
      $display("FAIL reset got %h want %h", act_vec(), exp_vec());
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_valid = (k < 3);
      in_instr = ADD_INSTR;
      in_pc    = 32'h100 + 32'(4 * k);
      @(negedge clk);
      vecs++;
      if (act_vec() !== exp_vec()) begin
        errs++;
        $display("FAIL stream c%0d got %h want %h", k, act_vec(), exp_vec());
      end
      if (k >= 1 && k <= 3) begin
        vecs++;
        if ({out_valid, in_ready, out_op, out_rs, out_rt, out_rd, out_func,
             out_pc, out_pc_next} !==
            {1'b1, 1'b1, 6'd0, 5'd9, 5'd10, 5'd8, 6'h20,
             32'h100 + 32'(4 * (k - 1)), 32'h104 + 32'(4 * (k - 1))}) begin
          errs++;
          $display("FAIL stream_fields c%0d got op=%h rs=%0d rt=%0d rd=%0d fn=%h pc=%h pcn=%h",
                   k, out_op, out_rs, out_rt, out_rd, out_func, out_pc, out_pc_next);
        end
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] got[$];
    int nxt = 0;
    for (int t = 0; t < 9; t++) begin
      out_ready = !(t >= 1 && t <= 3);
      in_valid  = (nxt < 3);
      in_instr  = ADD_INSTR;
      in_pc     = 32'h100 + 32'(4 * nxt);
      @(negedge clk);
      vecs++;
      if (act_vec() !== exp_vec()) begin
        errs++;
        $display("FAIL backpressure c%0d got %h want %h", t, act_vec(), exp_vec());
      end
      if (t == 4) begin
        vecs++;
        if ({stall_cnt, out_pc, in_ready} !== {16'd3, 32'h100, 1'b0}) begin
          errs++;
          $display("FAIL bp_hold stall=%0d pc=%h rdy=%b want 3 100 0",
                   stall_cnt, out_pc, in_ready);
        end
      end
      if (out_valid && out_ready) got.push_back(out_pc);
      if (in_valid && (mq.size() < 2)) nxt++;
      advance();
    end
    vecs++;
    if (got.size() != 3) begin
      errs++;
      $display("FAIL bp_order count got %0d want 3", got.size());
    end else begin
      for (int j = 0; j < 3; j++) begin
        vecs++;
        if (got[j] !== 32'h100 + 32'(4 * j)) begin
          errs++;
          $display("FAIL bp_order[%0d] got %h want %h", j, got[j], 32'h100 + 32'(4 * j));
        end
      end
    end
  endtask

  task automatic test_flush();
    for (int t = 0; t < 7; t++) begin
      out_ready = (t >= 3);
      in_valid  = (t <= 2);
      in_instr  = 32'h2000_0000 | 32'(t);
      in_pc     = 32'h400 + 32'(4 * t);
      flush     = (t == 2);
      @(negedge clk);
      vecs++;
      if (act_vec() !== exp_vec()) begin
        errs++;
        $display("FAIL flush c%0d got %h want %h", t, act_vec(), exp_vec());
      end
      if (t == 3) begin
        vecs++;
        if ({out_valid, out_instr, in_ready, flush_cnt, out_pc, d2_stall_cnt} !==
            {1'b0, 32'h0, 1'b1, 16'd1, 32'h400, 2'd3}) begin
          errs++;
          $display("FAIL flush_state v=%b i=%h r=%b fc=%0d pc=%h sc2=%0d",
                   out_valid, out_instr, in_ready, flush_cnt, out_pc, d2_stall_cnt);
        end
      end
      if (t >= 4) begin
        vecs++;
        if (out_valid !== 1'b0) begin
          errs++;
          $display("FAIL flush_ghost c%0d got out_valid=%b want 0", t, out_valid);
        end
      end
      advance();
    end
    flush = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int t = 0; t < 3; t++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = ADD_INSTR;
      in_pc     = 32'h200 + 32'(4 * t);
      @(negedge clk);
      vecs++;
      if (act_vec() !== exp_vec()) begin
        errs++;
        $display("FAIL areset_pre c%0d got %h want %h", t, act_vec(), exp_vec());
      end
      advance();
    end
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    vecs++;
    if (act_vec() !== exp_vec()) begin
      errs++;
      $display("FAIL areset_now got %h want %h", act_vec(), exp_vec());
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int t = 0; t < 3; t++) begin
      out_ready = 1'b1;
      in_valid  = (t == 0);
      in_pc     = 32'h300;
      @(negedge clk);
      vecs++;
      if (act_vec() !== exp_vec()) begin
        errs++;
        $display("FAIL areset_post c%0d got %h want %h", t, act_vec(), exp_vec());
      end
      if (t == 1) begin
        vecs++;
        if ({out_valid, out_pc} !== {1'b1, 32'h300}) begin
          errs++;
          $display("FAIL areset_latency got v=%b pc=%h want 1 300", out_valid, out_pc);
        end
      end
      advance();
    end
  endtask

  task automatic test_wrap();
    for (int t = 0; t < 3; t++) begin
      out_ready = 1'b1;
      in_valid  = (t == 0);
      in_instr  = ADD_INSTR;
      in_pc     = 32'hFFFF_FFFC;
      @(negedge clk);
      vecs++;
      if (act_vec() !== exp_vec()) begin
        errs++;
        $display("FAIL wrap c%0d got %h want %h", t, act_vec(), exp_vec());
      end
      if (t == 1) begin
        vecs++;
        if ({out_pc, out_pc_next} !== {32'hFFFF_FFFC, 32'h0}) begin
          errs++;
          $display("FAIL wrap_pcn got pc=%h pcn=%h want fffffffc 0", out_pc, out_pc_next);
        end
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 400; t++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 16) == 0;
      in_instr  = $urandom;
      in_pc     = $urandom;
      @(negedge clk);
      vecs++;
      if (act_vec() !== exp_vec()) begin
        errs++;
        $display("FAIL random c%0d got %h want %h", t, act_vec(), exp_vec());
      end
      advance();
    end
    flush = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/if_id_skid_reg.md
Name: if_id_skid_reg

Overview:
Parametrised IF/ID pipeline boundary. Replaces a bare stall/flush register with a valid/ready elastic stage holding a 2-entry skid buffer, so fetch and decode are decoupled without a combinational ready path. It decodes fixed MIPS instruction fields, computes the sequential PC, and keeps saturating stall and flush counters for performance debug. It sits between the fetch unit (upstream) and the decode/register-read stage (downstream).

Parameters:
XLEN, 32, PC width in bits
ILEN, 32, instruction width; must be 32 when field outputs are used
PC_INC, 4, increment applied for out_pc_next
FLUSH_INSTR, 32'h0000_0000, payload loaded into the main entry on flush (NOP)
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  fetch presents a beat
in_ready  out  1  stage can accept a beat; registered, equals ~skid_valid
in_instr  in  ILEN  fetched instruction
in_pc  in  XLEN  PC of in_instr
flush  in  1  kill all held beats (branch/jump redirect)
out_valid  out  1  main entry holds a live beat
out_ready  in  1  decode accepts; deassert to stall
out_instr  out  ILEN  main entry instruction
out_pc  out  XLEN  main entry PC
out_pc_next  out  XLEN  out_pc + PC_INC, modulo 2^XLEN
out_op  out  6  out_instr[31:26]
out_rs  out  5  out_instr[25:21]
out_rt  out  5  out_instr[20:16]
out_rd  out  5  out_instr[15:11]
out_shamt  out  5  out_instr[10:6]
out_func  out  6  out_instr[5:0]
stall_cnt  out  CNT_W  cycles with out_valid & ~out_ready, saturating
flush_cnt  out  CNT_W  flush assertions, saturating

Behaviour:
- Reset (async, any time including mid-transfer): main_valid=0, skid_valid=0, in_ready=1, out_instr=FLUSH_INSTR, out_pc=0, counters=0. Field outputs follow out_instr, so they are all 0 with the default NOP.
- Field outputs and out_pc_next are combinational from the main-entry registers only. There is no path from in_* to out_*.
- Handshake: accept = in_valid & in_ready; drain = out_valid & out_ready. Data is held stable while out_valid & ~out_ready.
- Latency: 1 cycle from accept to out_valid when the stage is empty or draining. Throughput is 1 beat/cycle with out_ready held high.
- Per-cycle update, flush not asserted:
  - drain & skid_valid: skid moves to main; if accept, the new beat goes to skid, else skid_valid=0.
  - drain & ~skid_valid: main loads the accepted beat; main_valid=accept.
  - ~main_valid: main loads the accepted beat.
  - main_valid & ~drain & accept: the beat goes to skid; skid_valid=1, so in_ready=0 next cycle.
  - Overflow is impossible: in_ready=0 whenever skid is full.
- Flush has highest priority: main_valid=0, skid_valid=0, out_instr=FLUSH_INSTR, out_pc unchanged. Any beat accepted in the same cycle is discarded. A drain in the same cycle still counts as consumed by downstream. in_ready=1 next cycle.
- Counters: +1 per qualifying cycle and hold at all-ones. stall_cnt samples pre-edge out_valid/out_ready. flush_cnt counts cycles with flush=1.
- in_valid=0 is legal at any time. in_instr and in_pc are don't-care when in_valid=0.

Decomposition:
- Package if_id_pkg: field bit positions (OP_HI/LO, RS_HI/LO, RT, RD, SHAMT, FUNC), NOP_INSTR constant, and an instruction-field struct typedef.
- Sub-module sat_counter (param W; inc, clk, rst -> cnt), instantiated twice.
- The skid/main datapath stays inline.

Test Plan:
1. Streaming: out_ready=1; send in_pc=0x100,0x104,0x108 with instr 0x012A4020 (add $8,$9,$10) -> each appears 1 cycle later with op=0, rs=9, rt=10, rd=8, func=0x20, out_pc_next=0x104,0x108,0x10C; in_ready stays 1.
2. Backpressure: out_ready=0 for 3 cycles during a stream -> 2nd beat goes to skid, in_ready=0 next cycle, out holds pc 0x100, stall_cnt=3. Release -> 0x104, 0x108 in order with no loss or duplication.
3. Flush while skid full and in_valid=1 -> next cycle out_valid=0, out_instr=0, in_ready=1, flush_cnt=1, and the flushed beats never appear.
4. Async reset asserted mid-stall between clock edges -> outputs clear immediately, before any clock edge; first beat after release appears with latency 1.
5. Wrap-around: in_pc=0xFFFF_FFFC -> out_pc_next=0x0000_0000. With CNT_W=2 and 5 stall cycles -> stall_cnt=3 and holds.
